// File: rtl/mac_drain_writeback.sv
// mac_drain_writeback: capture LANES MAC results, clear the bank, then bias/requantize/write one feature per beat (option DRAIN_RELU_EN selects ReLU clamp).
module mac_drain_writeback #(
  parameter int LANES  = 6,
  parameter int ACC_W  = 23,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 7,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [LANES*ACC_W-1:0]   mac_in,
  input  logic [LANES*8-1:0]       bias_in,
  input  logic                     wr_ready,
  output logic                     mac_clr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [OUT_W-1:0]         wr_data,
  output logic                     busy,
  output logic                     done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_EMIT = 2'd1, S_DONE = 2'd2;
  localparam int IW = $clog2(LANES);
  localparam int SW = ACC_W + SHIFT + 2;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (OUT_W - 1) - 1);
`ifdef DRAIN_RELU_EN
  localparam logic signed [SW-1:0] MIN_V = '0;
`else
  localparam logic signed [SW-1:0] MIN_V = -(SW'(2 ** (OUT_W - 1)));
`endif
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic mac_clr_q, mac_clr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [7:0] bias_q [LANES];
  logic signed [7:0] bias_d [LANES];
  logic signed [SW-1:0] sum, r;
  logic accept;
  assign wr_en   = state_q == S_EMIT;
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign mac_clr = mac_clr_q;
  assign accept  = wr_en && wr_ready;
  assign sum     = SW'(acc_q[idx_q]) + (SW'(bias_q[idx_q]) <<< SHIFT);
  assign r       = sum >>> SHIFT;
  assign wr_addr = wr_en ? base_q + ADDR_W'(idx_q) : '0;
  assign wr_data = !wr_en    ? '0 :
                   r > MAX_V ? MAX_V[OUT_W-1:0] :
                   r < MIN_V ? MIN_V[OUT_W-1:0] : r[OUT_W-1:0];
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    acc_d     = acc_q;
    bias_d    = bias_q;
    mac_clr_d = 1'b0;
    if (state_q == S_IDLE && start) begin
      state_d   = S_EMIT;
      idx_d     = '0;
      mac_clr_d = 1'b1;
      base_d    = base_addr;
      for (int i = 0; i < LANES; i++) begin
        acc_d[i]  = mac_in[i*ACC_W +: ACC_W];
        bias_d[i] = bias_in[i*8 +: 8];
      end
    end else if (accept) begin
      state_d = idx_q == LAST ? S_DONE : S_EMIT;
      idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mac_clr_q <= 1'b0;
      base_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i]  <= '0;
        bias_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mac_clr_q <= mac_clr_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      bias_q    <= bias_d;
    end
  end
endmodule
